// File: rtl/conv_7_8_mac_sched_if.sv
// Handshake/bus bundle between requester streams, the MAC scheduler and the
// result consumer. The slave modport is the scheduler's view.
interface conv_7_8_mac_sched_if #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1,
  parameter int ACC_W   = 32
);
  logic [NUM_REQ*8-1:0]  in_w;
  logic [NUM_REQ*16-1:0] in_x;
  logic [NUM_REQ-1:0]    in_valid;
  logic [NUM_REQ-1:0]    in_last;
  logic [NUM_REQ-1:0]    in_ready;
  logic [ACC_W-1:0]      out_data;
  logic [ID_W-1:0]       out_id;
  logic                  out_err;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output in_w, in_x, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_id, out_err, out_valid
  );

  modport slave (
    input  in_w, in_x, in_valid, in_last, out_ready,
    output in_ready, out_data, out_id, out_err, out_valid
  );
endinterface

// File: rtl/conv_7_8_mac_sched.sv
// Round-robin scheduler feeding one shared signed 8x16 multiplier and a
// dot-product accumulator. One packet is granted at a time; its beats are
// multiplied into a pipeline register and summed, and the result is held
// with the requester ID until the consumer accepts it.
//
//   state | meaning
//   IDLE  | arbitrate among in_valid from rr pointer; clear acc/count/err
//   RUN   | accept beats of the granted requester, multiply and accumulate
//   DRAIN | fold the last registered product into the accumulator
//   OUT   | present result; on handshake advance rr pointer, back to IDLE
module conv_7_8_mac_sched #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1,
  parameter int ACC_W   = 32,
  parameter int MAX_LEN = 64
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  conv_7_8_mac_sched_if.slave   bus
);

  localparam int CNT_W = $clog2(MAX_LEN + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_OUT   = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [ID_W-1:0]   grant_q, grant_d;
  logic [ID_W-1:0]   rr_q, rr_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic signed [23:0] p_q, p_d;
  logic              p_vld_q, p_vld_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;

  logic              pick_vld;
  logic [ID_W-1:0]   pick_id;
  logic [7:0]        w_sel;
  logic [15:0]       x_sel;
  logic [23:0]       w_ext, x_ext, prod;
  logic              accept;
  logic              last_sel;

  // Round-robin pick: first valid requester at or after the rr pointer.
  always_comb begin
    int idx;
    idx      = 0;
    pick_vld = 1'b0;
    pick_id  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_q) + k) % NUM_REQ;
      if (!pick_vld && bus.in_valid[idx]) begin
        pick_vld = 1'b1;
        pick_id  = ID_W'(idx);
      end
    end
  end

  // Granted requester's beat and its sign-extended 24-bit product.
  always_comb begin
    w_sel    = bus.in_w[int'(grant_q)*8 +: 8];
    x_sel    = bus.in_x[int'(grant_q)*16 +: 16];
    w_ext    = {{16{w_sel[7]}}, w_sel};
    x_ext    = {{8{x_sel[15]}}, x_sel};
    prod     = w_ext * x_ext;
    accept   = (state_q == S_RUN) && bus.in_valid[grant_q];
    last_sel = bus.in_last[grant_q];
  end

  // Only the granted requester sees ready, and only while in RUN.
  always_comb begin
    bus.in_ready = '0;
    if (state_q == S_RUN) bus.in_ready[grant_q] = 1'b1;
  end

  assign bus.out_valid = (state_q == S_OUT);
  assign bus.out_data  = acc_q;
  assign bus.out_id    = grant_q;
  assign bus.out_err   = err_q;

  // Next-state logic for the FSM, product pipeline and accumulator.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    acc_d   = acc_q;
    p_d     = p_q;
    p_vld_d = 1'b0;
    cnt_d   = cnt_q;
    err_d   = err_q;

    // The registered product lands one cycle after its beat was accepted.
    if (p_vld_q) acc_d = acc_q + ACC_W'(p_q);

    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          grant_d = pick_id;
          acc_d   = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (accept) begin
          p_d     = $signed(prod);
          p_vld_d = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
          if (last_sel) begin
            state_d = S_DRAIN;
          end else if (cnt_q == CNT_W'(MAX_LEN - 1)) begin
            // An explicit last on the final allowed beat is not a truncation.
            err_d   = 1'b1;
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        state_d = S_OUT;
      end
      S_OUT: begin
        if (bus.out_ready) begin
          rr_d    = (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + ID_W'(1);
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset discards any partially accumulated packet.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      acc_q   <= '0;
      p_q     <= '0;
      p_vld_q <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      acc_q   <= acc_d;
      p_q     <= p_d;
      p_vld_q <= p_vld_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_conv_7_8_mac_sched.sv
// Scoreboard bench for conv_7_8_mac_sched: per-requester beat streams are
// modelled as plain sums split at last/MAX_LEN; a monitor checks results.
module tb_conv_7_8_mac_sched;
  localparam int NR  = 3;
  localparam int IDW = 2;
  localparam int AW  = 24;
  localparam int ML  = 16;

  typedef struct {
    logic [7:0]  w;
    logic [15:0] x;
    bit          last;
  } beat_t;

  typedef struct {
    logic [AW-1:0] data;
    bit            err;
  } exp_t;

  logic ap_clk;
  logic ap_rst_n;

  conv_7_8_mac_sched_if #(.NUM_REQ(NR), .ID_W(IDW), .ACC_W(AW)) bus ();

  conv_7_8_mac_sched #(.NUM_REQ(NR), .ID_W(IDW), .ACC_W(AW), .MAX_LEN(ML)) dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .bus      (bus)
  );

  beat_t beat_q[NR][$];
  exp_t  exp_q[NR][$];
  int    id_log[$];
  logic [AW-1:0] m_sum[NR];
  int    m_cnt[NR];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int tot_acc = 0;
  int last_acc_cyc = 0;
  bit no_bubbles = 1;
  bit rdy_rand = 0;
  bit hold_low = 0;
  logic [AW-1:0] last_out_data = '0;
  bit last_out_err = 0;

  initial ap_clk = 0;
  always #5 ap_clk = ~ap_clk;

  initial forever begin
    @(posedge ap_clk);
    cyc++;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, cycle=%0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: a requester's beats are one stream; a packet closes on
  // last, or after ML beats with the truncation flag.
  task automatic push_beat(input int r, input int wi, input int xi, input bit last);
    beat_t b;
    exp_t  e;
    int    p;
    b.w = wi[7:0];
    b.x = xi[15:0];
    b.last = last;
    beat_q[r].push_back(b);
    p = wi * xi;
    m_sum[r] = m_sum[r] + p[AW-1:0];
    m_cnt[r]++;
    if (last || m_cnt[r] == ML) begin
      e.data = m_sum[r];
      e.err  = !last;
      exp_q[r].push_back(e);
      m_sum[r] = '0;
      m_cnt[r] = 0;
    end
  endtask

  task automatic flush_all();
    for (int r = 0; r < NR; r++) begin
      beat_q[r].delete();
      exp_q[r].delete();
      m_sum[r] = '0;
      m_cnt[r] = 0;
    end
    bus.in_valid = '0;
  endtask

  function automatic bit all_done();
    for (int r = 0; r < NR; r++)
      if (beat_q[r].size() != 0 || exp_q[r].size() != 0) return 0;
    return !bus.out_valid;
  endfunction

  task automatic wait_idle(input int budget, input string nm);
    int n = 0;
    while (!all_done() && n < budget) begin
      @(negedge ap_clk);
      n++;
    end
    chk({nm, "_done"}, 32'(all_done()), 32'd1);
  endtask

  // Driver: beats presented #1 after the edge; held until accepted.
  initial begin
    logic [NR-1:0] mask;
    int scyc;
    forever begin
      @(negedge ap_clk);
      mask = bus.in_valid & bus.in_ready;
      scyc = cyc;
      @(posedge ap_clk);
      #1;
      for (int r = 0; r < NR; r++) begin
        if (mask[r] && ap_rst_n && beat_q[r].size() > 0) begin
          void'(beat_q[r].pop_front());
          tot_acc++;
          last_acc_cyc = scyc;
        end
        if (!bus.in_valid[r] || mask[r] || beat_q[r].size() == 0) begin
          if (beat_q[r].size() > 0 && (no_bubbles || $urandom_range(0, 3) != 0)) begin
            bus.in_valid[r] = 1'b1;
            bus.in_w[r*8 +: 8]   = beat_q[r][0].w;
            bus.in_x[r*16 +: 16] = beat_q[r][0].x;
            bus.in_last[r]       = beat_q[r][0].last;
          end else begin
            bus.in_valid[r] = 1'b0;
          end
        end
      end
      bus.out_ready = hold_low ? 1'b0 : (rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1);
    end
  end

  // Monitor: pops the expected result of the reported requester.
  initial begin
    bit prev_ov = 0, prev_or = 0;
    logic [AW-1:0] prev_d = '0;
    logic [IDW-1:0] prev_id = '0;
    bit prev_err = 0;
    exp_t e;
    int id;
    forever begin
      @(negedge ap_clk);
      if (!ap_rst_n) begin
        prev_ov = 0;
      end else begin
        if (bus.out_valid) begin
          chk("in_ready_in_out", 32'(bus.in_ready), 32'd0);
          if (!prev_ov) chk("latency_last_to_valid", 32'(cyc - last_acc_cyc), 32'd2);
          if (prev_ov && !prev_or) begin
            chk("hold_data", 32'(bus.out_data), 32'(prev_d));
            chk("hold_id", 32'(bus.out_id), 32'(prev_id));
            chk("hold_err", 32'(bus.out_err), 32'(prev_err));
          end
          if (bus.out_ready) begin
            id = int'(bus.out_id);
            if (id >= NR || exp_q[id].size() == 0) begin
              chk("unexpected_result_id", 32'(id), 32'hFFFF_FFFF);
            end else begin
              e = exp_q[id].pop_front();
              chk("out_data", 32'(bus.out_data), 32'(e.data));
              chk("out_err", 32'(bus.out_err), 32'(e.err));
            end
            id_log.push_back(id);
            last_out_data = bus.out_data;
            last_out_err  = bus.out_err;
          end
        end
        prev_ov  = bus.out_valid;
        prev_or  = bus.out_ready;
        prev_d   = bus.out_data;
        prev_id  = bus.out_id;
        prev_err = bus.out_err;
      end
    end
  end

  initial begin
    int base, n, r, len;
    ap_rst_n = 0;
    bus.in_valid = '0;
    bus.in_last = '0;
    bus.in_w = '0;
    bus.in_x = '0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < NR; i++) begin
      m_sum[i] = '0;
      m_cnt[i] = 0;
    end
    #23;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_out_id", 32'(bus.out_id), 32'd0);
    chk("rst_out_err", 32'(bus.out_err), 32'd0);
    @(posedge ap_clk);
    #1 ap_rst_n = 1;

    // Arbitration: requesters 0 and 1 valid together right after reset.
    push_beat(0, 1, 2, 0); push_beat(0, 3, 4, 1);
    push_beat(1, -5, 6, 0); push_beat(1, 7, -8, 1);
    push_beat(0, 9, 10, 0); push_beat(0, -11, 12, 1);
    wait_idle(200, "arb");
    chk("arb_count", 32'(id_log.size()), 32'd3);
    if (id_log.size() == 3) begin
      chk("arb_id0", 32'(id_log[0]), 32'd0);
      chk("arb_id1", 32'(id_log[1]), 32'd1);
      chk("arb_id2", 32'(id_log[2]), 32'd0);
    end

    // Three-beat dot product on requester 0.
    push_beat(0, 2, 100, 0); push_beat(0, -3, 50, 0); push_beat(0, 127, -32768, 1);
    wait_idle(200, "dot3");
    chk("dot3_value", 32'(last_out_data), 32'(24'hC08032));

    // Back-pressure: result held, no beat accepted while in OUT.
    hold_low = 1;
    push_beat(1, 3, 4, 1);
    n = 0;
    while (!bus.out_valid && n < 100) begin @(negedge ap_clk); n++; end
    chk("bp_reach_out", 32'(bus.out_valid), 32'd1);
    push_beat(0, 1, 1, 1);
    base = tot_acc;
    repeat (10) @(negedge ap_clk);
    chk("bp_no_accept", 32'(tot_acc - base), 32'd0);
    chk("bp_valid_held", 32'(bus.out_valid), 32'd1);
    chk("bp_id", 32'(bus.out_id), 32'd1);
    hold_low = 0;
    wait_idle(200, "bp");

    // Truncation at ML: 18 unit beats -> ML with err, then 2 without.
    for (int i = 0; i < ML + 2; i++) push_beat(2, 1, 1, i == ML + 1);
    wait_idle(300, "trunc");
    chk("trunc_tail_value", 32'(last_out_data), 32'd2);

    // Wraparound: 16 products of 2^22 sum to 2^26 == 0 mod 2^24.
    for (int i = 0; i < 16; i++) push_beat(1, -128, -32768, i == 15);
    wait_idle(300, "wrap");
    chk("wrap_value", 32'(last_out_data), 32'd0);
    chk("wrap_err", 32'(last_out_err), 32'd0);

    // Random streams with bubbles and random out_ready.
    no_bubbles = 0;
    rdy_rand = 1;
    for (int p = 0; p < 40; p++) begin
      r = $urandom_range(0, NR - 1);
      len = $urandom_range(1, 20);
      for (int i = 0; i < len; i++)
        push_beat(r, int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 65535)) - 32768,
                  (i == len - 1) && ($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < NR; i++) push_beat(i, int'($urandom_range(0, 255)) - 128, 77, 1);
    wait_idle(20000, "random");

    // Reset in the middle of a packet: partial sum is discarded.
    no_bubbles = 1;
    rdy_rand = 0;
    @(negedge ap_clk);
    base = tot_acc;
    for (int i = 0; i < 4; i++) push_beat(0, 9, 9, i == 3);
    n = 0;
    while (tot_acc < base + 2 && n < 100) begin @(negedge ap_clk); n++; end
    chk("mid_reset_two_beats", 32'(tot_acc - base), 32'd2);
    #2;
    ap_rst_n = 0;
    flush_all();
    #1;
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_out_data", 32'(bus.out_data), 32'd0);
    chk("mid_rst_out_id", 32'(bus.out_id), 32'd0);
    chk("mid_rst_out_err", 32'(bus.out_err), 32'd0);
    @(posedge ap_clk);
    #3 ap_rst_n = 1;
    push_beat(0, 5, 7, 1);
    wait_idle(100, "post_reset");
    chk("post_reset_value", 32'(last_out_data), 32'd35);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/conv_7_8_mac_sched.md
# conv_7_8_mac_sched

Round-robin scheduler and accumulator for the shared signed 8x16 convolution multiplier. Up to NUM_REQ requester streams offer (weight, pixel) beat packets. The block grants one packet at a time and feeds its beats through a single 8x16 -> 24-bit signed product path. It accumulates the products into one dot-product result, tagged with the requester ID, and sits between the line-buffer/weight fetch stages and the conv output writer.

## Interface
Parameters:
- NUM_REQ, 2: number of requester streams (2..8).
- ID_W, 1: width of out_id; ceil(log2(NUM_REQ)), minimum 1.
- ACC_W, 32: accumulator/result width (>= 24).
- MAX_LEN, 64: maximum beats per packet; a packet is force-terminated at this count.

Ports:
- ap_clk, in, 1: single clock, rising edge.
- ap_rst_n, in, 1: asynchronous, active-low reset.
- in_w, in, NUM_REQ*8: signed weights; requester i uses bits [8i+7:8i].
- in_x, in, NUM_REQ*16: signed pixels; requester i uses bits [16i+15:16i].
- in_valid, in, NUM_REQ: beat valid per requester.
- in_last, in, NUM_REQ: last beat of packet per requester.
- in_ready, out, NUM_REQ: beat accept per requester.
- out_data, out, ACC_W: signed dot-product result.
- out_id, out, ID_W: requester index of the result.
- out_err, out, 1: packet truncated at MAX_LEN.
- out_valid, out, 1: result valid.
- out_ready, in, 1: result accept.

## Operation
- States: IDLE, RUN, DRAIN, OUT.
- IDLE
  - Round-robin pick among in_valid, starting from rr_ptr.
  - If any request is valid: register grant, clear acc, clear beat count and err, then go to RUN.
  - in_ready is 0 in this state.
  - in_last is not examined in IDLE.
- RUN
  - in_ready[grant] = 1; all other in_ready bits are 0.
  - Each accepted beat (in_valid[grant] & in_ready[grant]) registers p_reg = $signed(w) * $signed(x) (24-bit), sets p_vld, and increments the beat count.
  - Each cycle with p_vld set adds sign_extend(p_reg) to acc, modulo 2^ACC_W (wraps, no saturation).
  - Accepting a beat with in_last=1 moves to DRAIN.
  - Accepting beat number MAX_LEN without in_last sets err and moves to DRAIN.
  - Bubbles (in_valid low) are allowed: no product, no count change.
- DRAIN
  - in_ready is 0.
  - The final p_reg is added to acc.
  - Go to OUT.
- OUT
  - out_valid = 1; out_data = acc, out_id = grant, out_err = err, all held stable.
  - On out_valid & out_ready: rr_ptr = (grant+1) mod NUM_REQ, go to IDLE.
- A requester holding in_valid through a non-granted period must not lose beats; it is simply not ready.
- Reset (asynchronous, any state): state=IDLE, rr_ptr=0, acc=0, p_vld=0, count=0. A partially accumulated packet is discarded and never output.

## Timing
- Reset values: in_ready=0, out_valid=0, out_data=0, out_id=0, out_err=0.
- Arbitration costs 1 cycle: request seen in IDLE at cycle c, first beat can be accepted at cycle c+1.
- Throughput in RUN is 1 beat/cycle.
- Last beat accepted at cycle t -> out_valid high from cycle t+2 until handshake.
- A single-beat packet takes 4 cycles minimum from IDLE to return to IDLE (IDLE, RUN, DRAIN, OUT with out_ready=1).
- out_valid cannot drop without a handshake. All outputs are registered or state-decoded; there is no combinational path from out_ready to in_ready.

## Test plan
- Single requester 0, 3 beats (w,x) = (2,100),(-3,50),(127,-32768), last on 3rd -> out_data = 200-150-4161536 = -4161486, out_id=0, out_err=0, out_valid at t_last+2.
- Both requesters valid at once after reset, 2-beat packets -> req0 is served first, then req1, then req0 again; out_id sequence 0,1,0.
- Back-pressure: hold out_ready=0 for 10 cycles in OUT -> out_data/out_id stable, all in_ready=0, no beats accepted.
- MAX_LEN=4, requester sends 6 beats of (1,1) with no last -> result 4, out_err=1; the remaining beats start a new packet after grant.
- ACC_W=24, sixteen beats of (-128,-32768), each product +4194304 -> acc wraps to 0 (16*2^22 = 2^26 mod 2^24), out_err=0.
- Assert ap_rst_n low mid-RUN after 2 beats -> all outputs 0 immediately; after release, a new 1-beat packet (5,7) yields 35 with no residue from the discarded packet.
